// File: rtl/aes_dec_axil_master.sv
// ---------------------------------------------------------------------------
// aes_dec_axil_master
//
// AXI4-Lite initiator that runs one complete AES-decryption transaction
// against the AES_DEC slave. It writes the key to 0x10-0x1C and the
// ciphertext to 0x00-0x0C, optionally idles for the slave's decryption
// latency, reads the plaintext from 0x20-0x2C, and returns it on a
// valid/ready response port. Only one AXI access is in flight at a time.
//
// Ports:
//   ACLK, ARESET          clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready   request handshake, req_ready high only in IDLE
//   req_key, req_data     128-bit key and ciphertext, MSW goes first
//   resp_valid/resp_ready response handshake
//   resp_data, resp_err   plaintext and sticky "some BRESP/RRESP not OKAY"
//   M_AXI_*               AXI4-Lite master channels (AW, W, B, AR, R)
// ---------------------------------------------------------------------------
module aes_dec_axil_master #(
  parameter int ADDR_W      = 6,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [127:0]      req_key,
  input  logic [127:0]      req_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [127:0]      resp_data,
  output logic              resp_err,
  output logic [ADDR_W-1:0] M_AXI_AWADDR,
  output logic [2:0]        M_AXI_AWPROT,
  output logic              M_AXI_AWVALID,
  input  logic              M_AXI_AWREADY,
  output logic [31:0]       M_AXI_WDATA,
  output logic [3:0]        M_AXI_WSTRB,
  output logic              M_AXI_WVALID,
  input  logic              M_AXI_WREADY,
  input  logic [1:0]        M_AXI_BRESP,
  input  logic              M_AXI_BVALID,
  output logic              M_AXI_BREADY,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic [2:0]        M_AXI_ARPROT,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic [31:0]       M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_WAIT    = 3'd3,
    S_RD_REQ  = 3'd4,
    S_RD_RESP = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t         state_q, state_d;
  logic [127:0]   key_q, data_q, pt_q;
  // Word counter: 0-7 while writing (0-3 key, 4-7 data); it wraps to 0
  // after the 8th write and bits [1:0] then serve as the read index.
  logic [2:0]     cnt_q;
  logic           aw_done_q, w_done_q;
  logic           err_q;
  logic [31:0]    wait_q;

  logic           aw_hs, w_hs, wr_both_done;
  logic [127:0]   wr_src;
  logic [31:0]    wr_word;

  assign aw_hs        = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs         = M_AXI_WVALID  && M_AXI_WREADY;
  // AW and W may complete in either order or together.
  assign wr_both_done = (aw_done_q || aw_hs) && (w_done_q || w_hs);

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB  = 4'b1111;
  assign resp_data    = pt_q;
  assign resp_err     = err_q;

  // Select the 32-bit write word addressed by the counter, MSW first.
  always_comb begin
    wr_src = cnt_q[2] ? data_q : key_q;
    case (cnt_q[1:0])
      2'd0:    wr_word = wr_src[127:96];
      2'd1:    wr_word = wr_src[95:64];
      2'd2:    wr_word = wr_src[63:32];
      default: wr_word = wr_src[31:0];
    endcase
  end

  // FSM state register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) state_d = S_WR_REQ;
        else           state_d = S_IDLE;
      end
      S_WR_REQ: begin
        if (wr_both_done) state_d = S_WR_RESP;
        else              state_d = S_WR_REQ;
      end
      S_WR_RESP: begin
        if (M_AXI_BVALID) begin
          if (cnt_q == 3'd7) state_d = (WAIT_CYCLES == 0) ? S_RD_REQ : S_WAIT;
          else               state_d = S_WR_REQ;
        end else begin
          state_d = S_WR_RESP;
        end
      end
      S_WAIT: begin
        if (wait_q == 32'(WAIT_CYCLES - 1)) state_d = S_RD_REQ;
        else                                state_d = S_WAIT;
      end
      S_RD_REQ: begin
        if (M_AXI_ARREADY) state_d = S_RD_RESP;
        else               state_d = S_RD_REQ;
      end
      S_RD_RESP: begin
        if (M_AXI_RVALID) state_d = (cnt_q[1:0] == 2'd3) ? S_DONE : S_RD_REQ;
        else              state_d = S_RD_RESP;
      end
      S_DONE: begin
        if (resp_ready) state_d = S_IDLE;
        else            state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; everything idles at zero outside its own state so that
  // an asynchronous reset clears the bus immediately.
  always_comb begin
    req_ready     = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    resp_valid    = 1'b0;
    M_AXI_AWADDR  = '0;
    M_AXI_WDATA   = 32'h0000_0000;
    M_AXI_ARADDR  = '0;
    case (state_q)
      S_IDLE:    req_ready = !ARESET;
      S_WR_REQ: begin
        // Key words land at 0x10+4i, data words at 0x00+4i.
        M_AXI_AWVALID = !aw_done_q;
        M_AXI_WVALID  = !w_done_q;
        M_AXI_AWADDR  = ADDR_W'({~cnt_q[2], cnt_q[1:0], 2'b00});
        M_AXI_WDATA   = wr_word;
      end
      S_WR_RESP: M_AXI_BREADY = 1'b1;
      S_WAIT:    req_ready    = 1'b0;
      S_RD_REQ: begin
        M_AXI_ARVALID = 1'b1;
        M_AXI_ARADDR  = ADDR_W'({2'b10, cnt_q[1:0], 2'b00});
      end
      S_RD_RESP: M_AXI_RREADY = 1'b1;
      S_DONE:    resp_valid   = 1'b1;
      default:   req_ready    = 1'b0;
    endcase
  end

  // Datapath: request capture, word counter, handshake flags, plaintext, error.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      key_q     <= 128'd0;
      data_q    <= 128'd0;
      pt_q      <= 128'd0;
      cnt_q     <= 3'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
      wait_q    <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            key_q     <= req_key;
            data_q    <= req_data;
            err_q     <= 1'b0;
            cnt_q     <= 3'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end
        end
        S_WR_REQ: begin
          if (wr_both_done) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end else begin
            aw_done_q <= aw_done_q || aw_hs;
            w_done_q  <= w_done_q  || w_hs;
          end
        end
        S_WR_RESP: begin
          if (M_AXI_BVALID) begin
            err_q  <= err_q | (M_AXI_BRESP != 2'b00);
            cnt_q  <= cnt_q + 3'd1;
            wait_q <= 32'd0;
          end
        end
        S_WAIT: wait_q <= wait_q + 32'd1;
        S_RD_RESP: begin
          if (M_AXI_RVALID) begin
            err_q <= err_q | (M_AXI_RRESP != 2'b00);
            cnt_q <= cnt_q + 3'd1;
            case (cnt_q[1:0])
              2'd0:    pt_q[127:96] <= M_AXI_RDATA;
              2'd1:    pt_q[95:64]  <= M_AXI_RDATA;
              2'd2:    pt_q[63:32]  <= M_AXI_RDATA;
              default: pt_q[31:0]   <= M_AXI_RDATA;
            endcase
          end
        end
        default: err_q <= err_q;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_dec_axil_master.sv
// ---------------------------------------------------------------------------
// Bench for aes_dec_axil_master: a behavioural AXI4-Lite memory slave with
// configurable READY latencies, random B/R stalls and an injectable write
// error, plus a protocol monitor. Expected values come from the address map
// and word ordering rules (plain arithmetic), never from the DUT.
// ---------------------------------------------------------------------------
module tb_aes_dec_axil_master;

  logic         ACLK = 1'b0;
  logic         ARESET = 1'b1;
  logic         req_valid = 1'b0, req_ready;
  logic [127:0] req_key = 128'd0, req_data = 128'd0;
  logic         resp_valid, resp_ready = 1'b0;
  logic [127:0] resp_data;
  logic         resp_err;
  logic [5:0]   AWADDR, ARADDR;
  logic [2:0]   AWPROT, ARPROT;
  logic         AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic         ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0]  WDATA, RDATA;
  logic [3:0]   WSTRB;
  logic [1:0]   BRESP, RRESP;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  aes_dec_axil_master #(.ADDR_W(6), .WAIT_CYCLES(0)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
  );

  // ---------------- slave model ----------------
  int          aw_lat = 0, w_lat = 0, ar_lat = 0, max_stall = 0;
  logic [5:0]  err_waddr = 6'h3F;
  logic [31:0] rd_mem [0:15];
  logic [31:0] wr_mem [0:15];
  int          aw_wait, w_wait, ar_wait, b_timer, r_timer, acc_cnt;
  logic        aw_have, w_have, b_pend, r_pend, b_err;
  logic [5:0]  aw_addr_q, r_addr_q, s_waddr;
  logic [31:0] w_data_q, s_wdata;
  logic        aw_hs, w_hs, ar_hs;
  logic [5:0]  wlog_a [$];
  logic [31:0] wlog_d [$];

  assign AWREADY = AWVALID && (aw_wait >= aw_lat);
  assign WREADY  = WVALID  && (w_wait  >= w_lat);
  assign ARREADY = ARVALID && (ar_wait >= ar_lat);
  assign aw_hs   = AWVALID && AWREADY;
  assign w_hs    = WVALID  && WREADY;
  assign ar_hs   = ARVALID && ARREADY;
  assign s_waddr = aw_hs ? AWADDR : aw_addr_q;
  assign s_wdata = w_hs  ? WDATA  : w_data_q;
  assign BVALID  = b_pend && (b_timer == 0);
  assign BRESP   = b_err ? 2'b10 : 2'b00;
  assign RVALID  = r_pend && (r_timer == 0);
  assign RDATA   = rd_mem[r_addr_q[5:2]];
  assign RRESP   = 2'b00;

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_timer <= 0; r_timer <= 0;
      aw_have <= 1'b0; w_have <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0; b_err <= 1'b0;
      aw_addr_q <= 6'd0; r_addr_q <= 6'd0; w_data_q <= 32'd0;
    end else begin
      aw_wait <= (AWVALID && !AWREADY) ? aw_wait + 1 : 0;
      w_wait  <= (WVALID  && !WREADY)  ? w_wait  + 1 : 0;
      ar_wait <= (ARVALID && !ARREADY) ? ar_wait + 1 : 0;
      if (aw_hs) begin aw_have <= 1'b1; aw_addr_q <= AWADDR; end
      if (w_hs)  begin w_have  <= 1'b1; w_data_q  <= WDATA;  end
      if ((aw_have || aw_hs) && (w_have || w_hs) && !b_pend) begin
        wr_mem[s_waddr[5:2]] <= s_wdata;
        wlog_a.push_back(s_waddr);
        wlog_d.push_back(s_wdata);
        aw_have <= 1'b0;
        w_have  <= 1'b0;
        b_pend  <= 1'b1;
        b_err   <= (s_waddr == err_waddr);
        b_timer <= int'($urandom_range(max_stall));
      end
      if (b_pend) begin
        if (b_timer != 0) b_timer <= b_timer - 1;
        else if (BREADY) begin b_pend <= 1'b0; acc_cnt <= acc_cnt + 1; end
      end
      if (ar_hs) begin
        r_pend   <= 1'b1;
        r_addr_q <= ARADDR;
        r_timer  <= int'($urandom_range(max_stall));
      end
      if (r_pend) begin
        if (r_timer != 0) r_timer <= r_timer - 1;
        else if (RREADY) begin r_pend <= 1'b0; acc_cnt <= acc_cnt + 1; end
      end
    end
  end

  // ---------------- protocol monitor ----------------
  logic        p_aw_pend, p_w_pend, p_ar_pend, p_aw_hs, p_w_hs, p_ar_hs;
  logic [5:0]  p_awaddr, p_araddr;
  logic [31:0] p_wdata;
  int          viol = 0, bcnt = 0;
  logic [7:0]  viol_vec;

  assign viol_vec[0] = p_aw_pend && (!AWVALID || AWADDR !== p_awaddr);
  assign viol_vec[1] = p_w_pend  && (!WVALID  || WDATA  !== p_wdata);
  assign viol_vec[2] = p_ar_pend && (!ARVALID || ARADDR !== p_araddr);
  assign viol_vec[3] = p_aw_hs && AWVALID;
  assign viol_vec[4] = p_w_hs  && WVALID;
  assign viol_vec[5] = p_ar_hs && ARVALID;
  assign viol_vec[6] = (AWVALID || WVALID) && (b_pend || r_pend);
  assign viol_vec[7] = ARVALID && (bcnt < 8 || b_pend || r_pend);

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      p_aw_pend <= 1'b0; p_w_pend <= 1'b0; p_ar_pend <= 1'b0;
      p_aw_hs <= 1'b0; p_w_hs <= 1'b0; p_ar_hs <= 1'b0;
      p_awaddr <= 6'd0; p_araddr <= 6'd0; p_wdata <= 32'd0;
      bcnt <= 0;
    end else begin
      viol <= viol + $countones(viol_vec);
      p_aw_pend <= AWVALID && !AWREADY; p_awaddr <= AWADDR; p_aw_hs <= aw_hs;
      p_w_pend  <= WVALID  && !WREADY;  p_wdata  <= WDATA;  p_w_hs  <= w_hs;
      p_ar_pend <= ARVALID && !ARREADY; p_araddr <= ARADDR; p_ar_hs <= ar_hs;
      if (req_valid && req_ready) bcnt <= 0;
      else if (BVALID && BREADY)  bcnt <= bcnt + 1;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [5:0] exp_waddr(input int i);
    return (i < 4) ? 6'(16 + 4 * i) : 6'(4 * (i - 4));
  endfunction

  function automatic logic [31:0] exp_wword(input logic [127:0] k, input logic [127:0] d, input int i);
    logic [127:0] src;
    src = (i < 4) ? k : d;
    return src[127 - 32 * (i % 4) -: 32];
  endfunction

  function automatic logic [127:0] exp_plain();
    return {rd_mem[8], rd_mem[9], rd_mem[10], rd_mem[11]};
  endfunction

  function automatic logic [303:0] exp_log(input logic [127:0] k, input logic [127:0] d);
    logic [303:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i*38 +: 38] = {exp_waddr(i), exp_wword(k, d, i)};
    return v;
  endfunction

  function automatic logic [303:0] act_log();
    logic [303:0] v;
    v = '0;
    for (int i = 0; i < 8 && i < wlog_a.size(); i++) v[i*38 +: 38] = {wlog_a[i], wlog_d[i]};
    return v;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
    rd_mem[8] = a; rd_mem[9] = b; rd_mem[10] = c; rd_mem[11] = d;
  endtask

  // One full request/response; lat is resp_valid cycle minus accept cycle.
  task automatic run_txn(input logic [127:0] k, input logic [127:0] d, input int hold,
                         output logic [127:0] pt, output logic er, output int lat);
    int t;
    int hs;
    @(negedge ACLK);
    wlog_a.delete(); wlog_d.delete();
    req_key = k; req_data = d; req_valid = 1'b1;
    t = 0;
    while (req_ready !== 1'b1 && t < 200) begin @(negedge ACLK); t++; end
    hs = cyc;
    @(negedge ACLK);
    req_valid = 1'b0;
    t = 0;
    while (resp_valid !== 1'b1 && t < 3000) begin @(negedge ACLK); t++; end
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL txn_timeout: resp_valid=%b after %0d cycles, required 1", resp_valid, t);
    end
    lat = cyc - hs; pt = resp_data; er = resp_err;
    repeat (hold) @(negedge ACLK);
    resp_ready = 1'b1;
    @(negedge ACLK);
    resp_ready = 1'b0;
  endtask

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

  task automatic test_reset();
    #2;
    checks++;
    if ({req_ready, resp_valid, resp_err, AWVALID, WVALID, BREADY, ARVALID, RREADY} !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl: got %b, required 00000000",
        {req_ready, resp_valid, resp_err, AWVALID, WVALID, BREADY, ARVALID, RREADY});
    end
    checks++;
    if ({AWADDR, ARADDR, WDATA, resp_data} !== 172'd0) begin
      errors++; $display("FAIL reset_data: awaddr=%h araddr=%h wdata=%h resp_data=%h, required all 0",
        AWADDR, ARADDR, WDATA, resp_data);
    end
    checks++;
    if ({AWPROT, ARPROT, WSTRB} !== 10'b000_000_1111) begin
      errors++; $display("FAIL reset_const: prot/strb=%b, required 0000001111", {AWPROT, ARPROT, WSTRB});
    end
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b, required 1", req_ready); end
  endtask

  task automatic test_fips();
    logic [127:0] pt; logic er; int lat;
    aw_lat = 0; w_lat = 0; ar_lat = 0; max_stall = 0;
    preload(FIPS_PT[127:96], FIPS_PT[95:64], FIPS_PT[63:32], FIPS_PT[31:0]);
    run_txn(FIPS_KEY, FIPS_CT, 0, pt, er, lat);
    checks++;
    if (pt !== FIPS_PT) begin errors++; $display("FAIL fips_data: got %h, required %h", pt, FIPS_PT); end
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL fips_err: got %b, required 0", er); end
    checks++;
    if (wlog_a.size() != 8) begin errors++; $display("FAIL fips_wcount: got %0d, required 8", wlog_a.size()); end
    for (int i = 0; i < 8 && i < wlog_a.size(); i++) begin
      checks++;
      if (wlog_a[i] !== exp_waddr(i) || wlog_d[i] !== exp_wword(FIPS_KEY, FIPS_CT, i)) begin
        errors++; $display("FAIL fips_write%0d: got %h/%h, required %h/%h", i, wlog_a[i], wlog_d[i],
          exp_waddr(i), exp_wword(FIPS_KEY, FIPS_CT, i));
      end
    end
  endtask

  task automatic test_ideal_latency();
    logic [127:0] pt; logic er; int lat; int v0;
    aw_lat = 0; w_lat = 0; ar_lat = 0; max_stall = 0;
    preload(32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D);
    v0 = viol;
    run_txn({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 0, pt, er, lat);
    checks++;
    if (lat != 25) begin errors++; $display("FAIL ideal_latency: got %0d cycles, required 25", lat); end
    checks++;
    if (pt !== 128'hDEADBEEF0123456789ABCDEFCAFEF00D) begin
      errors++; $display("FAIL ideal_data: got %h, required DEADBEEF0123456789ABCDEFCAFEF00D", pt);
    end
    checks++;
    if (viol != v0) begin errors++; $display("FAIL ideal_protocol: got %0d violations, required 0", viol - v0); end
  endtask

  task automatic test_stall();
    logic [127:0] pt; logic er; int lat; int v0; int a0;
    aw_lat = 3; w_lat = 0; ar_lat = 1; max_stall = 5;
    preload(32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D);
    v0 = viol; a0 = acc_cnt;
    run_txn(FIPS_KEY, FIPS_CT, 0, pt, er, lat);
    checks++;
    if (pt !== 128'hDEADBEEF0123456789ABCDEFCAFEF00D) begin
      errors++; $display("FAIL stall_data: got %h, required DEADBEEF0123456789ABCDEFCAFEF00D", pt);
    end
    checks++;
    if (viol != v0) begin errors++; $display("FAIL stall_protocol: got %0d violations, required 0", viol - v0); end
    checks++;
    if (acc_cnt - a0 != 12) begin errors++; $display("FAIL stall_accesses: got %0d, required 12", acc_cnt - a0); end
    checks++;
    if (act_log() !== exp_log(FIPS_KEY, FIPS_CT)) begin
      errors++; $display("FAIL stall_writes: got %h, required %h", act_log(), exp_log(FIPS_KEY, FIPS_CT));
    end
  endtask

  task automatic test_random();
    logic [127:0] pt, k, d; logic er; int lat; int v0;
    for (int it = 0; it < 5; it++) begin
      aw_lat = int'($urandom_range(3)); w_lat = int'($urandom_range(3));
      ar_lat = int'($urandom_range(3)); max_stall = int'($urandom_range(5));
      preload($urandom, $urandom, $urandom, $urandom);
      k = {$urandom, $urandom, $urandom, $urandom};
      d = {$urandom, $urandom, $urandom, $urandom};
      v0 = viol;
      run_txn(k, d, int'($urandom_range(3)), pt, er, lat);
      checks++;
      if (pt !== exp_plain() || er !== 1'b0) begin
        errors++; $display("FAIL random%0d_resp: got %h err=%b, required %h err=0", it, pt, er, exp_plain());
      end
      checks++;
      if (act_log() !== exp_log(k, d) || wlog_a.size() != 8) begin
        errors++; $display("FAIL random%0d_writes: got %h (%0d), required %h (8)", it, act_log(), wlog_a.size(), exp_log(k, d));
      end
      checks++;
      if (viol != v0) begin errors++; $display("FAIL random%0d_protocol: got %0d violations, required 0", it, viol - v0); end
    end
  endtask

  task automatic test_bresp_err();
    logic [127:0] pt; logic er; int lat; int a0;
    aw_lat = 0; w_lat = 1; ar_lat = 0; max_stall = 2;
    preload(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    err_waddr = 6'h08;
    a0 = acc_cnt;
    run_txn(FIPS_KEY, FIPS_CT, 0, pt, er, lat);
    err_waddr = 6'h3F;
    checks++;
    if (er !== 1'b1) begin errors++; $display("FAIL berr_flag: got %b, required 1", er); end
    checks++;
    if (acc_cnt - a0 != 12) begin errors++; $display("FAIL berr_accesses: got %0d, required 12", acc_cnt - a0); end
    checks++;
    if (pt !== 128'h11111111222222223333333344444444) begin
      errors++; $display("FAIL berr_data: got %h, required 11111111222222223333333344444444", pt);
    end
    run_txn(FIPS_KEY, FIPS_CT, 0, pt, er, lat);
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL berr_clean_next: got %b, required 0", er); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] k2, d2, held; int t;
    logic [127:0] exp1;
    aw_lat = 0; w_lat = 0; ar_lat = 0; max_stall = 0;
    preload($urandom, $urandom, $urandom, $urandom);
    exp1 = exp_plain();
    k2 = {$urandom, $urandom, $urandom, $urandom};
    d2 = {$urandom, $urandom, $urandom, $urandom};
    @(negedge ACLK);
    req_key = FIPS_KEY; req_data = FIPS_CT; req_valid = 1'b1;
    t = 0;
    while (req_ready !== 1'b1 && t < 200) begin @(negedge ACLK); t++; end
    @(negedge ACLK);
    req_key = k2; req_data = d2;          // second request held from here on
    t = 0;
    while (resp_valid !== 1'b1 && t < 3000) begin @(negedge ACLK); t++; end
    held = resp_data;
    checks++;
    if (held !== exp1 || resp_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_first: got %h valid=%b, required %h valid=1", held, resp_valid, exp1);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== held || req_ready !== 1'b0) begin
        errors++; $display("FAIL b2b_hold%0d: valid=%b data=%h req_ready=%b, required 1/%h/0",
          i, resp_valid, resp_data, req_ready, held);
      end
    end
    preload($urandom, $urandom, $urandom, $urandom);
    resp_ready = 1'b1;
    @(negedge ACLK);
    resp_ready = 1'b0;
    wlog_a.delete(); wlog_d.delete();
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_accept: req_ready=%b resp_valid=%b, required 1/0", req_ready, resp_valid);
    end
    @(negedge ACLK);
    req_valid = 1'b0;
    t = 0;
    while (resp_valid !== 1'b1 && t < 3000) begin @(negedge ACLK); t++; end
    checks++;
    if (resp_data !== exp_plain() || act_log() !== exp_log(k2, d2)) begin
      errors++; $display("FAIL b2b_second: got %h, required %h", resp_data, exp_plain());
    end
    resp_ready = 1'b1;
    @(negedge ACLK);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    logic [127:0] pt; logic er; int lat; int t; logic seen;
    aw_lat = 3; w_lat = 0; ar_lat = 0; max_stall = 0;
    @(negedge ACLK);
    wlog_a.delete(); wlog_d.delete();
    req_key = FIPS_KEY; req_data = FIPS_CT; req_valid = 1'b1;
    t = 0;
    while (req_ready !== 1'b1 && t < 200) begin @(negedge ACLK); t++; end
    @(negedge ACLK);
    req_valid = 1'b0;
    t = 0;
    while (!(wlog_a.size() == 5 && AWVALID === 1'b1) && t < 500) begin @(negedge ACLK); t++; end
    checks++;
    if (!(wlog_a.size() == 5 && AWVALID === 1'b1)) begin
      errors++; $display("FAIL rst_reach_w6: writes=%0d awvalid=%b, required 5/1", wlog_a.size(), AWVALID);
    end
    ARESET = 1'b1;
    #1;
    checks++;
    if ({req_ready, resp_valid, AWVALID, WVALID, BREADY, ARVALID, RREADY} !== 7'h00) begin
      errors++; $display("FAIL rst_midop_outputs: got %b, required 0000000",
        {req_ready, resp_valid, AWVALID, WVALID, BREADY, ARVALID, RREADY});
    end
    seen = 1'b0;
    repeat (3) begin @(negedge ACLK); seen = seen | resp_valid; end
    ARESET = 1'b0;
    repeat (4) begin @(negedge ACLK); seen = seen | resp_valid; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rst_midop_noresp: resp_valid seen=%b, required 0", seen); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_midop_ready: got %b, required 1", req_ready); end
    aw_lat = 0;
    preload(FIPS_PT[127:96], FIPS_PT[95:64], FIPS_PT[63:32], FIPS_PT[31:0]);
    run_txn(FIPS_KEY, FIPS_CT, 0, pt, er, lat);
    checks++;
    if (pt !== FIPS_PT || er !== 1'b0 || act_log() !== exp_log(FIPS_KEY, FIPS_CT)) begin
      errors++; $display("FAIL rst_midop_after: got %h err=%b, required %h err=0", pt, er, FIPS_PT);
    end
  endtask

  initial begin
    acc_cnt = 0;
    for (int i = 0; i < 16; i++) rd_mem[i] = 32'd0;
    test_reset();
    test_fips();
    test_ideal_latency();
    test_stall();
    test_random();
    test_bresp_err();
    test_back_to_back();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
